// File: rtl/sega_pad_pkg.sv
// Shared types and constants for the DB9 Sega/Atari pad poller: sequencer
// states, button bit positions and the select level driven in each state.
package sega_pad_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        S0   = 4'd1,
        S1   = 4'd2,
        S2   = 4'd3,
        S3   = 4'd4,
        S4   = 4'd5,
        S5   = 4'd6,
        S6   = 4'd7,
        S7   = 4'd8
    } pad_state_e;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_Z     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_X     = 10;
    localparam int BTN_MODE  = 11;

    // Bit n is the select level while in state S<n>.
    localparam logic [7:0] SEL_PATTERN = 8'b10101010;

    function automatic logic sel_level(input pad_state_e s);
        logic [3:0] idx;
        idx = s - S0;
        if (s == IDLE) begin
            return 1'b1;
        end
        return SEL_PATTERN[idx[2:0]];
    endfunction

endpackage

// File: rtl/sega_pad_decode.sv
// Per-port decoder: synchronises the raw pins, captures them into shadow
// registers as the sequencer walks the select pattern, and commits atomically.
module sega_pad_decode
    import sega_pad_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  pins_raw,
    input  pad_state_e  state,
    input  logic        step_end,
    input  logic        commit,
    output logic [11:0] joy,
    output logic        six,
    output logic        md
);

    // The synchroniser stores active-high values so a cleared flop means "released".
    logic [5:0]  sync1_q, sync1_d;
    logic [5:0]  act_q, act_d;
    logic [11:0] sh_q, sh_d;
    logic        md_sh_q, md_sh_d;
    logic        six_sh_q, six_sh_d;
    logic [11:0] joy_q, joy_d;
    logic        six_q, six_d;
    logic        md_q, md_d;

    always_comb begin
        sync1_d  = ~pins_raw;
        act_d    = sync1_q;
        sh_d     = sh_q;
        md_sh_d  = md_sh_q;
        six_sh_d = six_sh_q;
        joy_d    = joy_q;
        six_d    = six_q;
        md_d     = md_q;

        if (step_end) begin
            case (state)
                S1: begin
                    sh_d[BTN_RIGHT:BTN_UP] = act_q[3:0];
                    sh_d[BTN_B]            = act_q[4];
                    sh_d[BTN_C]            = act_q[5];
                end
                S2: begin
                    // A Mega Drive pad pulls left and right low together while select is low.
                    if (act_q[3] && act_q[2]) begin
                        md_sh_d        = 1'b1;
                        sh_d[BTN_START] = act_q[5];
                        sh_d[BTN_A]     = act_q[4];
                    end else begin
                        md_sh_d        = 1'b0;
                        sh_d[BTN_START] = 1'b0;
                        sh_d[BTN_A]     = 1'b0;
                    end
                end
                S4: begin
                    six_sh_d = md_sh_q && (&act_q[3:0]);
                end
                S5: begin
                    sh_d[BTN_MODE:BTN_Z] = six_sh_q ? act_q[3:0] : 4'b0000;
                end
                default: begin
                end
            endcase
        end

        if (commit) begin
            joy_d = sh_q;
            six_d = six_sh_q;
            md_d  = md_sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 6'd0;
            act_q    <= 6'd0;
            sh_q     <= 12'd0;
            md_sh_q  <= 1'b0;
            six_sh_q <= 1'b0;
            joy_q    <= 12'd0;
            six_q    <= 1'b0;
            md_q     <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            act_q    <= act_d;
            sh_q     <= sh_d;
            md_sh_q  <= md_sh_d;
            six_sh_q <= six_sh_d;
            joy_q    <= joy_d;
            six_q    <= six_d;
            md_q     <= md_d;
        end
    end

    assign joy = joy_q;
    assign six = six_q;
    assign md  = md_q;

endmodule

// File: rtl/sega_pad_reader.sv
// Two-port DB9 pad poller: a tick-divided sequencer drives the shared select
// line and strobes the per-port decoders, publishing results once per poll.
module sega_pad_reader
    import sega_pad_pkg::*;
#(
    parameter int TICK_DIV   = 400,
    parameter int IDLE_STEPS = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  joy1_pins,
    input  logic [5:0]  joy2_pins,
    output logic        sel_o,
    output logic [11:0] joy1,
    output logic [11:0] joy2,
    output logic        six1,
    output logic        six2,
    output logic        md1,
    output logic        md2,
    output logic        poll_done
);

    logic [15:0] tick_q, tick_d;
    logic [15:0] step_q, step_d;
    pad_state_e  state_q, state_d;
    logic        sel_q, sel_d;
    logic        poll_done_q, poll_done_d;
    logic        step_end;
    logic        commit;

    always_comb begin
        step_end    = (tick_q == 16'(TICK_DIV - 1));
        tick_d      = step_end ? 16'd0 : tick_q + 16'd1;
        state_d     = state_q;
        step_d      = step_q;
        commit      = 1'b0;

        if (step_end) begin
            case (state_q)
                IDLE: begin
                    if (step_q == 16'(IDLE_STEPS - 1)) begin
                        step_d  = 16'd0;
                        state_d = S0;
                    end else begin
                        step_d = step_q + 16'd1;
                    end
                end
                S0: state_d = S1;
                S1: state_d = S2;
                S2: state_d = S3;
                S3: state_d = S4;
                S4: state_d = S5;
                S5: state_d = S6;
                S6: state_d = S7;
                S7: begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        // Select follows the state it is entering so the level changes with the state.
        sel_d       = sel_level(state_d);
        poll_done_d = commit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q      <= 16'd0;
            step_q      <= 16'd0;
            state_q     <= IDLE;
            sel_q       <= 1'b1;
            poll_done_q <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            step_q      <= step_d;
            state_q     <= state_d;
            sel_q       <= sel_d;
            poll_done_q <= poll_done_d;
        end
    end

    sega_pad_decode u_port1 (
        .clk      (clk),
        .reset    (reset),
        .pins_raw (joy1_pins),
        .state    (state_q),
        .step_end (step_end),
        .commit   (commit),
        .joy      (joy1),
        .six      (six1),
        .md       (md1)
    );

    sega_pad_decode u_port2 (
        .clk      (clk),
        .reset    (reset),
        .pins_raw (joy2_pins),
        .state    (state_q),
        .step_end (step_end),
        .commit   (commit),
        .joy      (joy2),
        .six      (six2),
        .md       (md2)
    );

    assign sel_o     = sel_q;
    assign poll_done = poll_done_q;

endmodule

// File: tb/tb_sega_pad_reader.sv
// Directed bench for sega_pad_reader with behavioural pads that react to sel_o.
module tb_sega_pad_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  joy1_pins;
  logic [5:0]  joy2_pins;
  logic        sel_o;
  logic [11:0] joy1, joy2;
  logic        six1, six2, md1, md2;
  logic        poll_done;

  // pad type: 0 open, 1 SMS, 2 MD 3-button, 3 MD 6-button; buttons active-high
  int          t1 = 0, t2 = 0;
  logic [11:0] b1 = 12'h000, b2 = 12'h000;

  int          errors = 0;
  int          checks = 0;

  int          low_cnt = 0;
  int          high_run = 0;
  logic        sel_prev = 1'b1;
  int          toggles = 0;
  logic        sel_seen = 1'b1;

  sega_pad_reader #(.TICK_DIV(4), .IDLE_STEPS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .joy1_pins (joy1_pins),
    .joy2_pins (joy2_pins),
    .sel_o     (sel_o),
    .joy1      (joy1),
    .joy2      (joy2),
    .six1      (six1),
    .six2      (six2),
    .md1       (md1),
    .md2       (md2),
    .poll_done (poll_done)
  );

  always #5 clk = ~clk;

  // Pad model: returns active-low pins for the given select level and low-pulse count.
  function automatic logic [5:0] pad_pins(input int t, input logic [11:0] b,
                                          input logic sel, input int cnt);
    logic [5:0] act;
    case (t)
      1: act = {b[5], b[4], b[3:0]};
      2: act = sel ? {b[5], b[4], b[3:0]} : {b[7], b[6], 2'b11, b[1:0]};
      3: begin
        if (sel) act = (cnt == 3) ? {b[5], b[4], b[11:8]} : {b[5], b[4], b[3:0]};
        else if (cnt == 3) act = {b[7], b[6], 4'hF};
        else if (cnt >= 4) act = {b[7], b[6], 4'h0};
        else act = {b[7], b[6], 2'b11, b[1:0]};
      end
      default: act = 6'h00;
    endcase
    return ~act;
  endfunction

  assign joy1_pins = pad_pins(t1, b1, sel_o, low_cnt);
  assign joy2_pins = pad_pins(t2, b2, sel_o, low_cnt);

  // 6-button counter: counts select falls, cleared after a long select-high stretch.
  always @(negedge clk) begin
    sel_prev <= sel_o;
    high_run <= sel_o ? high_run + 1 : 0;
    if (sel_prev && !sel_o) low_cnt <= low_cnt + 1;
    else if (high_run >= 12) low_cnt <= 0;
    sel_seen <= sel_o;
    if (sel_o != sel_seen) toggles <= toggles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_poll(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!poll_done && cyc < 300);
    check("poll_seen", 32'(poll_done), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int snap;
    int drift;

    // Reset and first poll with nothing plugged in
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'(sel_o), 32'd1);
    check("rst_joy1", 32'(joy1), 32'h000);
    check("rst_done", 32'(poll_done), 32'd0);
    reset = 1'b0;
    wait_poll(cyc);
    check("first_latency", 32'(cyc), 32'd64);
    check("open_joy1", 32'(joy1), 32'h000);
    check("open_md1", 32'(md1), 32'd0);
    check("open_six1", 32'(six1), 32'd0);
    check("open_joy2", 32'(joy2), 32'h000);

    // SMS on port 1 (up + p6), 3-button MD on port 2 (start + A)
    t1 = 1; b1 = 12'h011;
    t2 = 2; b2 = 12'h0C0;
    wait_poll(cyc);
    check("period", 32'(cyc), 32'd64);
    check("sms_joy1", 32'(joy1), 32'h011);
    check("sms_md1", 32'(md1), 32'd0);
    check("sms_six1", 32'(six1), 32'd0);
    check("md3_joy2", 32'(joy2), 32'h0C0);
    check("md3_md2", 32'(md2), 32'd1);
    check("md3_six2", 32'(six2), 32'd0);

    // 6-button pads: port 1 Y+Mode, port 2 X+Mode; three polls
    t1 = 3; b1 = 12'hA00;
    t2 = 3; b2 = 12'hC00;
    for (int p = 0; p < 3; p++) begin
      snap = toggles;
      wait_poll(cyc);
      check("six_toggles", 32'(toggles - snap), 32'd8);
      check("six_joy1", 32'(joy1), 32'hA00);
      check("six_md1", 32'(md1), 32'd1);
      check("six_six1", 32'(six1), 32'd1);
      check("six_joy2", 32'(joy2), 32'hC00);
      check("six_six2", 32'(six2), 32'd1);
    end

    // 6-button pad with directions and face buttons mixed: up, C, start, Z
    b2 = 12'h1A1;
    wait_poll(cyc);
    check("six_mix_joy2", 32'(joy2), 32'h1A1);

    // Pin change during S3: outputs hold until commit
    t1 = 1; b1 = 12'h011;
    wait_poll(cyc);
    check("pre_mid_joy1", 32'(joy1), 32'h011);
    repeat (46) @(negedge clk);
    b1 = 12'h002;
    drift = 0;
    cyc = 0;
    while (!poll_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!poll_done && joy1 != 12'h011) drift++;
    end
    check("mid_stable", 32'(drift), 32'd0);
    check("mid_commit_joy1", 32'(joy1), 32'h011);
    @(negedge clk);
    check("done_width", 32'(poll_done), 32'd0);
    wait_poll(cyc);
    check("mid_next_joy1", 32'(joy1), 32'h002);

    // Reset during S4 abandons the poll
    repeat (48) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_sel", 32'(sel_o), 32'd1);
    check("mid_rst_done", 32'(poll_done), 32'd0);
    check("mid_rst_joy1", 32'(joy1), 32'h000);
    check("mid_rst_md2", 32'(md2), 32'd0);
    reset = 1'b0;
    wait_poll(cyc);
    check("rst_latency", 32'(cyc), 32'd64);
    check("after_rst_joy1", 32'(joy1), 32'h002);
    check("after_rst_joy2", 32'(joy2), 32'h1A1);
    check("after_rst_six2", 32'(six2), 32'd1);

    // SMS with right + p9 on port 1, port 2 unplugged
    b1 = 12'h028;
    t2 = 0;
    wait_poll(cyc);
    check("sms_c_joy1", 32'(joy1), 32'h028);
    check("unplug_joy2", 32'(joy2), 32'h000);
    check("unplug_md2", 32'(md2), 32'd0);
    check("unplug_six2", 32'(six2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
